// File: rtl/linear_layer_fifo_pkg.sv
// Shared helpers for the Linear_Layer start-token FIFOs: occupancy-counter width
// and the address-range sanity check used when a FIFO is elaborated.
package linear_layer_fifo_pkg;

    // The counter must hold every value 0..depth, hence depth+1 states.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit addr_fits(input int addr_width, input int depth);
        return (1 << addr_width) >= depth;
    endfunction

    localparam int DEFAULT_DEPTH = 2;
    localparam int CNT_W         = cnt_width(DEFAULT_DEPTH);

endpackage

// File: rtl/linear_layer_start_fifo_srl_storage.sv
// SRL-style shift array: each write enters at entry 0 and pushes older tokens
// one slot deeper; the head is picked out by the controller's read address.
module linear_layer_start_fifo_srl_storage #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // No reset: contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/linear_layer_start_fifo_srl.sv
// Start-token FIFO with HLS full_n/empty_n handshake over an SRL shift array.
// Define LINEAR_LAYER_START_FIFO_STATUS_EN to expose occupancy and capacity outputs.
module linear_layer_start_fifo_srl
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
`ifdef LINEAR_LAYER_START_FIFO_STATUS_EN
    ,
    output logic [cnt_width(DEPTH)-1:0] if_num_data_valid,
    output logic [cnt_width(DEPTH)-1:0] if_fifo_cap
`endif
);

    localparam int CNT_WIDTH = cnt_width(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    if (!addr_fits(ADDR_WIDTH, DEPTH)) begin : g_bad_addr_width
        $error("linear_layer_start_fifo_srl: ADDR_WIDTH too small for DEPTH");
    end

    logic                  push;
    logic                  pop;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic [CNT_WIDTH-1:0]  cnt_next_m1;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_next;

    // Requests against a deasserted flag fall away here, so they never touch state.
    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read  & if_read_ce  & if_empty_n;

    // cnt alone encodes EMPTY / PARTIAL / FULL; push+pop together leaves it
    // unchanged because the shift slides the next-oldest token into addr.
    always_comb begin
        cnt_next    = cnt;
        cnt_next_m1 = CNT_ZERO;
        addr_next   = '0;
        if (push && !pop) begin
            cnt_next = cnt + CNT_ONE;
        end else if (pop && !push) begin
            cnt_next = cnt - CNT_ONE;
        end
        if (cnt_next != CNT_ZERO) begin
            cnt_next_m1 = cnt_next - CNT_ONE;
            addr_next   = ADDR_WIDTH'(cnt_next_m1);
        end
    end

    // Flags are registered from the next count so they line up with the new head.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= CNT_ZERO;
            addr       <= '0;
            if_empty_n <= 1'b0;
            if_full_n  <= 1'b1;
        end else begin
            cnt        <= cnt_next;
            addr       <= addr_next;
            if_empty_n <= (cnt_next != CNT_ZERO);
            if_full_n  <= (cnt_next != CNT_FULL);
        end
    end

    linear_layer_start_fifo_srl_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk  (clk),
        .we   (push),
        .addr (addr),
        .din  (if_din),
        .dout (if_dout)
    );

`ifdef LINEAR_LAYER_START_FIFO_STATUS_EN
    assign if_num_data_valid = cnt;
    assign if_fifo_cap       = CNT_FULL;
`endif

endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// Self-checking bench: three FIFO depths (2, 4, 1) share one stimulus stream and
// are compared against queue-based reference models.
module tb_linear_layer_start_fifo_srl;

    logic       clk = 1'b0;
    logic       reset;
    logic       if_write_ce;
    logic       if_write;
    logic       if_read_ce;
    logic       if_read;
    logic [3:0] if_din;

    logic       a_full_n, a_empty_n, b_full_n, b_empty_n, c_full_n, c_empty_n;
    logic [3:0] a_dout, b_dout, c_dout;
`ifdef LINEAR_LAYER_START_FIFO_STATUS_EN
    logic [1:0] a_num, a_cap;
    logic [2:0] b_num, b_cap;
    logic [0:0] c_num, c_cap;
`endif

    logic [2:0] emp_v;
    logic [2:0] ful_v;
    logic [3:0] dout_v [3];

    logic [3:0] q [3][$];
    int         cap [3] = '{2, 4, 1};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign emp_v     = {c_empty_n, b_empty_n, a_empty_n};
    assign ful_v     = {c_full_n, b_full_n, a_full_n};
    assign dout_v[0] = a_dout;
    assign dout_v[1] = b_dout;
    assign dout_v[2] = c_dout;

    linear_layer_start_fifo_srl #(.DATA_WIDTH(4), .ADDR_WIDTH(1), .DEPTH(2)) dut_a (
        .clk(clk), .reset(reset),
        .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(a_full_n),
        .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(a_dout), .if_empty_n(a_empty_n)
`ifdef LINEAR_LAYER_START_FIFO_STATUS_EN
        , .if_num_data_valid(a_num), .if_fifo_cap(a_cap)
`endif
    );

    linear_layer_start_fifo_srl #(.DATA_WIDTH(4), .ADDR_WIDTH(2), .DEPTH(4)) dut_b (
        .clk(clk), .reset(reset),
        .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(b_full_n),
        .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(b_dout), .if_empty_n(b_empty_n)
`ifdef LINEAR_LAYER_START_FIFO_STATUS_EN
        , .if_num_data_valid(b_num), .if_fifo_cap(b_cap)
`endif
    );

    linear_layer_start_fifo_srl #(.DATA_WIDTH(4), .ADDR_WIDTH(1), .DEPTH(1)) dut_c (
        .clk(clk), .reset(reset),
        .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(c_full_n),
        .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(c_dout), .if_empty_n(c_empty_n)
`ifdef LINEAR_LAYER_START_FIFO_STATUS_EN
        , .if_num_data_valid(c_num), .if_fifo_cap(c_cap)
`endif
    );

    // Drive one cycle of inputs, advance the reference queues, and settle past the edge.
    task automatic tick(input logic rst, input logic w, input logic wce,
                        input logic r, input logic rce, input logic [3:0] din);
        bit do_push, do_pop;
        reset = rst; if_write = w; if_write_ce = wce;
        if_read = r; if_read_ce = rce; if_din = din;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                q[i].delete();
            end else begin
                do_push = w && wce && (q[i].size() < cap[i]);
                do_pop  = r && rce && (q[i].size() > 0);
                if (do_pop)  void'(q[i].pop_front());
                if (do_push) q[i].push_back(din);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0, 4'h0);
        tick(1, 1, 1, 1, 1, 4'h7);
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 0, 1, 1, 4'h0);
            checks++;
            if (a_empty_n !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_empty_n: got %b expected 0", a_empty_n);
            end
            checks++;
            if (a_full_n !== 1'b1) begin
                errors++; $display("[TB] FAIL reset_full_n: got %b expected 1", a_full_n);
            end
        end
    endtask

    task automatic test_fill_drain();
        tick(1, 0, 0, 0, 0, 4'h0);
        tick(0, 1, 1, 0, 0, 4'h1);
        checks++;
        if (a_empty_n !== 1'b1 || a_dout !== 4'h1) begin
            errors++; $display("[TB] FAIL first_push: got empty_n=%b dout=%h expected 1/1", a_empty_n, a_dout);
        end
        tick(0, 1, 1, 0, 0, 4'h0);
        checks++;
        if (a_full_n !== 1'b0) begin
            errors++; $display("[TB] FAIL full_after_two: got %b expected 0", a_full_n);
        end
        tick(0, 1, 1, 0, 0, 4'hA);
        checks++;
        if (a_full_n !== 1'b0 || a_dout !== 4'h1) begin
            errors++; $display("[TB] FAIL refused_write: got full_n=%b dout=%h expected 0/1", a_full_n, a_dout);
        end
        tick(0, 0, 0, 1, 1, 4'h0);
        checks++;
        if (a_dout !== 4'h0 || a_empty_n !== 1'b1 || a_full_n !== 1'b1) begin
            errors++; $display("[TB] FAIL first_pop: got dout=%h empty_n=%b full_n=%b expected 0/1/1", a_dout, a_empty_n, a_full_n);
        end
        tick(0, 0, 0, 1, 1, 4'h0);
        checks++;
        if (a_empty_n !== 1'b0 || a_full_n !== 1'b1) begin
            errors++; $display("[TB] FAIL drained: got empty_n=%b full_n=%b expected 0/1", a_empty_n, a_full_n);
        end
    endtask

    task automatic test_back_to_back();
        tick(1, 0, 0, 0, 0, 4'h0);
        tick(0, 1, 1, 0, 0, 4'h0);
        for (int k = 1; k < 10; k++) begin
            tick(0, 1, 1, 1, 1, 4'(k));
            checks++;
            if (a_dout !== 4'(k) || a_empty_n !== 1'b1 || a_full_n !== 1'b1) begin
                errors++; $display("[TB] FAIL stream_%0d: got dout=%h empty_n=%b full_n=%b expected %h/1/1", k, a_dout, a_empty_n, a_full_n, 4'(k));
            end
        end
    endtask

    task automatic test_full_push_pop();
        tick(1, 0, 0, 0, 0, 4'h0);
        tick(0, 1, 1, 0, 0, 4'h3);
        tick(0, 1, 1, 0, 0, 4'h5);
        tick(0, 1, 1, 1, 1, 4'h9);
        checks++;
        if (a_dout !== 4'h5 || a_full_n !== 1'b1 || a_empty_n !== 1'b1) begin
            errors++; $display("[TB] FAIL full_push_pop: got dout=%h full_n=%b empty_n=%b expected 5/1/1", a_dout, a_full_n, a_empty_n);
        end
        tick(0, 0, 0, 1, 1, 4'h0);
        checks++;
        if (a_empty_n !== 1'b0) begin
            errors++; $display("[TB] FAIL full_write_dropped: got empty_n=%b expected 0", a_empty_n);
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 0, 0, 4'h0);
        tick(0, 1, 1, 0, 0, 4'h6);
        tick(0, 1, 1, 0, 0, 4'h7);
        tick(1, 1, 1, 1, 1, 4'h8);
        checks++;
        if (a_empty_n !== 1'b0 || a_full_n !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_mid: got empty_n=%b full_n=%b expected 0/1", a_empty_n, a_full_n);
        end
        tick(0, 0, 0, 1, 1, 4'h0);
        checks++;
        if (a_empty_n !== 1'b0 || b_empty_n !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_mid_stays_empty: got a=%b b=%b expected 0/0", a_empty_n, b_empty_n);
        end
`ifdef LINEAR_LAYER_START_FIFO_STATUS_EN
        checks++;
        if (a_num !== 2'd0) begin
            errors++; $display("[TB] FAIL reset_mid_cnt: got %0d expected 0", a_num);
        end
`endif
    endtask

`ifdef LINEAR_LAYER_START_FIFO_STATUS_EN
    task automatic test_status();
        tick(1, 0, 0, 0, 0, 4'h0);
        for (int k = 1; k <= 3; k++) begin
            tick(0, 1, 1, 0, 0, 4'(k));
            checks++;
            if (b_num !== 3'(k)) begin
                errors++; $display("[TB] FAIL num_data_valid_%0d: got %0d expected %0d", k, b_num, k);
            end
        end
        checks++;
        if (b_cap !== 3'd4 || a_cap !== 2'd2 || c_cap !== 1'd1) begin
            errors++; $display("[TB] FAIL fifo_cap: got %0d/%0d/%0d expected 4/2/1", b_cap, a_cap, c_cap);
        end
    endtask
`endif

    // Random traffic on all three depths, including occasional mid-stream resets.
    task automatic test_random();
        logic rst;
        tick(1, 0, 0, 0, 0, 4'h0);
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            tick(rst, 1'($urandom), ($urandom_range(0, 3) != 0),
                 1'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom));
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (emp_v[i] !== (q[i].size() != 0) || ful_v[i] !== (q[i].size() != cap[i])) begin
                    errors++; $display("[TB] FAIL rand_flags[%0d] cyc %0d: got empty_n=%b full_n=%b expected occupancy %0d of %0d",
                                       i, n, emp_v[i], ful_v[i], q[i].size(), cap[i]);
                end
                if (q[i].size() != 0) begin
                    checks++;
                    if (dout_v[i] !== q[i][0]) begin
                        errors++; $display("[TB] FAIL rand_dout[%0d] cyc %0d: got %h expected %h", i, n, dout_v[i], q[i][0]);
                    end
                end
            end
`ifdef LINEAR_LAYER_START_FIFO_STATUS_EN
            checks++;
            if (b_num !== 3'(q[1].size())) begin
                errors++; $display("[TB] FAIL rand_num: got %0d expected %0d", b_num, q[1].size());
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b1; if_write = 1'b0; if_write_ce = 1'b0;
        if_read = 1'b0; if_read_ce = 1'b0; if_din = 4'h0;
        $display("[TB] starting");
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_push_pop();
        test_reset_mid();
`ifdef LINEAR_LAYER_START_FIFO_STATUS_EN
        test_status();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
